// File: rtl/soml_addr_sched_pkg.sv
// SOML address sweep: shared defaults, state encoding, width helper.
// Imported by the interface, counter and sequencer top.
package soml_addr_sched_pkg;

  localparam int SOML_N_COLS = 2;
  localparam int SOML_N_ROWS = 4;
  localparam int SOML_N_SI   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2m1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/soml_addr_sched_if.sv
// Control/address bundle between decoder control, the sweep
// sequencer and the metric datapath.
interface soml_addr_sched_if
  import soml_addr_sched_pkg::*;
#(
  parameter int N_COLS = SOML_N_COLS,
  parameter int N_ROWS = SOML_N_ROWS,
  parameter int N_SI   = SOML_N_SI
);
  localparam int CW = clog2m1(N_COLS);
  localparam int RW = clog2m1(N_ROWS);
  localparam int SW = clog2m1(N_SI);

  logic          start;
  logic          abort;
  logic          out_ready;
  logic          addr_valid;
  logic [CW-1:0] addr_colS;
  logic [RW-1:0] addr_rowH;
  logic [SW-1:0] addr_Si;
  logic          acc_clr;
  logic          acc_last;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, out_ready,
    input  addr_valid, addr_colS, addr_rowH, addr_Si,
    input  acc_clr, acc_last, busy, done
  );

  modport slave (
    input  start, abort, out_ready,
    output addr_valid, addr_colS, addr_rowH, addr_Si,
    output acc_clr, acc_last, busy, done
  );
endinterface

// File: rtl/soml_wrap_cnt.sv
// Modulo-MOD counter with synchronous clear; wrap flags the
// increment that rolls MOD-1 back to 0 and feeds the next stage.
module soml_wrap_cnt
  import soml_addr_sched_pkg::*;
#(
  parameter  int MOD = 2,
  localparam int W   = clog2m1(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  logic [W-1:0] r_cnt;
  logic         w_top;

  assign w_top = (r_cnt == W'(MOD - 1));
  assign wrap  = inc & w_top;
  assign cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= w_top ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/soml_addr_sched.sv
// SOML address sweep sequencer: walks (Si,rowH,colS) once per
// start, colS fastest, over a valid/ready handshake.
module soml_addr_sched
  import soml_addr_sched_pkg::*;
#(
  parameter int N_COLS = SOML_N_COLS,
  parameter int N_ROWS = SOML_N_ROWS,
  parameter int N_SI   = SOML_N_SI
) (
  input logic               clk,
  input logic               rst,
  soml_addr_sched_if.slave  bus
);
  localparam int CW = clog2m1(N_COLS);
  localparam int RW = clog2m1(N_ROWS);
  localparam int SW = clog2m1(N_SI);

  state_t        r_state;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_fire;
  logic          w_clr;
  logic          w_wc;
  logic          w_wr;
  logic          w_ws;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [SW-1:0] w_si;

  assign w_fire = r_valid & bus.out_ready;
  // abort clears even alongside the final fire, so no wrap leaks out
  assign w_clr  = bus.abort | ((r_state == ST_IDLE) & bus.start);

  soml_wrap_cnt #(.MOD(N_COLS)) u_col (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_fire), .cnt(w_col), .wrap(w_wc)
  );

  soml_wrap_cnt #(.MOD(N_ROWS)) u_row (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_wc), .cnt(w_row), .wrap(w_wr)
  );

  soml_wrap_cnt #(.MOD(N_SI)) u_si (
    .clk(clk), .rst(rst), .clr(w_clr),
    .inc(w_wr), .cnt(w_si), .wrap(w_ws)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start & !bus.abort) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_ws) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_valid = r_valid;
  assign bus.addr_colS  = w_col;
  assign bus.addr_rowH  = w_row;
  assign bus.addr_Si    = w_si;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.acc_clr    = r_valid & (w_col == '0) & (w_row == '0);
  assign bus.acc_last   = r_valid
                        & (w_col == CW'(N_COLS - 1))
                        & (w_row == RW'(N_ROWS - 1));
endmodule

// File: tb/tb_soml_addr_sched.sv
// Directed bench for soml_addr_sched: default 2x4x16 sweep plus
// a 1x2x4 instance; expectations computed from the tuple index.
module tb_soml_addr_sched;
  import soml_addr_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soml_addr_sched_if #(.N_COLS(2), .N_ROWS(4), .N_SI(16)) bus ();
  soml_addr_sched_if #(.N_COLS(1), .N_ROWS(2), .N_SI(4))  bus2 ();

  soml_addr_sched #(.N_COLS(2), .N_ROWS(4), .N_SI(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  soml_addr_sched #(.N_COLS(1), .N_ROWS(2), .N_SI(4)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pk(input int v, input int c,
                                     input int l, input int s,
                                     input int r, input int k);
    return 32'((v << 26) | (c << 25) | (l << 24)
             | (s << 16) | (r << 8) | k);
  endfunction

  function automatic logic [31:0] o1();
    return pk(int'(bus.addr_valid), int'(bus.acc_clr),
              int'(bus.acc_last), int'(bus.addr_Si),
              int'(bus.addr_rowH), int'(bus.addr_colS));
  endfunction

  function automatic logic [31:0] o2();
    return pk(int'(bus2.addr_valid), int'(bus2.acc_clr),
              int'(bus2.acc_last), int'(bus2.addr_Si),
              int'(bus2.addr_rowH), int'(bus2.addr_colS));
  endfunction

  // tuple i of the 2x4x16 sweep: colS=i%2, rowH=(i/2)%4, Si=i/8
  function automatic logic [31:0] e1(input int i);
    return pk(1, int'(i % 8 == 0), int'(i % 8 == 7),
              i / 8, (i / 2) % 4, i % 2);
  endfunction

  function automatic logic [31:0] e2(input int i);
    return pk(1, int'(i % 2 == 0), int'(i % 2 == 1),
              i / 2, i % 2, 0);
  endfunction

  // {busy, done, valid}
  function automatic logic [31:0] st1();
    return {29'd0, bus.busy, bus.done, bus.addr_valid};
  endfunction

  function automatic logic [31:0] st2();
    return {29'd0, bus2.busy, bus2.done, bus2.addr_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int cyc;
    int nclr;
    int nlast;
    int nd;
    int nv;
    logic r;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    bus2.start = 1'b0;
    bus2.abort = 1'b0;
    bus2.out_ready = 1'b0;

    #2 rst = 1'b0;
    #10;
    chk("rst_tuple", o1(), 32'd0);
    chk("rst_stat", st1(), 32'd0);
    chk("rst_stat2", st2(), 32'd0);
    #1 rst = 1'b1;
    step();
    chk("idle_after_rst", st1(), 32'd0);

    // full sweep, ready held high
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("t1_tup", o1(), e1(i));
      step();
    end
    chk("t1_done", st1(), 32'b110);
    chk("t1_addr0", o1(), 32'd0);
    step();
    chk("t1_idle", st1(), 32'd0);

    // random backpressure
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    idx = 0; cyc = 0; nclr = 0; nlast = 0;
    while (idx < 128 && cyc < 4000) begin
      r = 1'($urandom_range(0, 1));
      bus.out_ready = r;
      chk("t2_tup", o1(), e1(idx));
      if (r) begin
        if (bus.acc_clr) nclr++;
        if (bus.acc_last) nlast++;
        idx++;
      end
      step();
      cyc++;
    end
    chk("t2_count", 32'(idx), 32'd128);
    chk("t2_clr", 32'(nclr), 32'd16);
    chk("t2_last", 32'(nlast), 32'd16);
    chk("t2_done", st1(), 32'b110);
    bus.out_ready = 1'b1;
    step();

    // abort after 37 fires
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 37; i++) begin
      chk("t3_tup", o1(), e1(i));
      step();
    end
    chk("t3_pre", o1(), e1(37));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t3_stat", st1(), 32'd0);
    chk("t3_addr", o1(), 32'd0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) nd++;
    end
    chk("t3_nodone", 32'(nd), 32'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 127; i++) begin
      chk("t3_restart", o1(), e1(i));
      step();
    end
    chk("t3_final", o1(), e1(127));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t3_abort_last", st1(), 32'd0);
    chk("t3_abort_addr", o1(), 32'd0);
    step();
    chk("t3_abort_nodone", st1(), 32'd0);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_idle", st1(), 32'd0);
    step();
    chk("sa_idle2", st1(), 32'd0);

    // start during RUN is ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("t4_tup", o1(), e1(i));
      bus.start = (i == 10);
      step();
    end
    bus.start = 1'b0;
    chk("t4_done", st1(), 32'b110);
    nd = 0; nv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done) nd++;
      if (bus.addr_valid) nv++;
    end
    chk("t4_single_done", 32'(nd), 32'd0);
    chk("t4_no_resweep", 32'(nv), 32'd0);

    // asynchronous reset mid-cycle during RUN
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre", o1(), e1(5));
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_stat", st1(), 32'd0);
    chk("t5_rst_addr", o1(), 32'd0);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_post", st1(), 32'd0);
    end

    // 1x2x4 instance
    bus2.out_ready = 1'b1;
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_tup", o2(), e2(i));
      step();
    end
    chk("t6_done", st2(), 32'b110);
    step();
    chk("t6_idle", st2(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
